// File: rtl/out_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : out_fifo_ctrl
// Brief    : Memory-mapped character output FIFO with a status register and a
//            sent counter. The sink side uses a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module out_fifo_ctrl #(
  parameter int          DEPTH = 8,
  parameter logic [31:0] BASE  = 32'h0000_4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  pdata,
  output logic        pvalid,
  input  logic        pready
);

  localparam int          C_AW       = $clog2(DEPTH);
  localparam int          C_LW       = C_AW + 1;
  localparam logic [31:0] C_STATUS   = BASE + 32'd4;
  localparam logic [31:0] C_COUNT    = BASE + 32'd8;
  localparam logic [C_LW-1:0] C_FULL_LVL = C_LW'(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [C_AW-1:0] r_wptr;
  logic [C_AW-1:0] r_rptr;
  logic [C_LW-1:0] r_level;
  logic            r_ovf;
  logic [31:0]     r_sent;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_ovf_set;
  logic            w_ovf_clr;
  logic [7:0]      w_push_byte;
  logic [6:0]      w_level7;

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == C_FULL_LVL);
  assign w_push      = (daddr == BASE) && (dwe != 4'b0000);
  assign w_pop       = !w_empty && pready;
  // A push into a full FIFO is still accepted when the head leaves this cycle.
  assign w_push_ok   = w_push && (!w_full || w_pop);
  assign w_ovf_set   = w_push && w_full && !w_pop;
  assign w_ovf_clr   = (daddr == C_STATUS) && dwe[0] && dwdata[2];
  assign w_push_byte = dwe[0] ? dwdata[7:0] : 8'h00;
  assign w_level7    = 7'(r_level);

  assign pvalid = !w_empty;
  assign pdata  = w_empty ? 8'h00 : r_mem[r_rptr];

  // Storage is deliberately not reset; only the pointers/level define validity.
  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) begin
      r_mem[r_wptr] <= w_push_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_sent  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + C_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_AW'(1);
        r_sent <= r_sent + 32'd1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + C_LW'(1);
        2'b01:   r_level <= r_level - C_LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    drdata = 32'h0000_0000;
    if (daddr == C_STATUS) begin
      drdata = {17'd0, w_level7, 5'd0, r_ovf, w_full, w_empty};
    end else if (daddr == C_COUNT) begin
      drdata = r_sent;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_out_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_fifo_ctrl
// Brief    : Directed self-checking bench for out_fifo_ctrl (DEPTH = 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_fifo_ctrl;

  localparam int          C_DEPTH  = 8;
  localparam logic [31:0] C_BASE   = 32'h0000_4000;
  localparam logic [31:0] C_STATUS = C_BASE + 32'd4;
  localparam logic [31:0] C_COUNT  = C_BASE + 32'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] daddr = '0;
  logic [31:0] dwdata = '0;
  logic [3:0]  dwe = '0;
  logic [31:0] drdata;
  logic [7:0]  pdata;
  logic        pvalid;
  logic        pready = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] rx[$];

  out_fifo_ctrl #(.DEPTH(C_DEPTH), .BASE(C_BASE)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .pdata(pdata), .pvalid(pvalid), .pready(pready)
  );

  always #5 clk = ~clk;

  // Inputs are stable between posedge+1 and the next posedge, so the negedge
  // view is exactly what the DUT pops on the following edge.
  always @(negedge clk) begin
    if (reset === 1'b0 && pvalid === 1'b1 && pready === 1'b1) rx.push_back(pdata);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_bus();
    daddr = '0; dwdata = '0; dwe = '0;
  endtask

  task automatic push(input logic [7:0] b);
    daddr = C_BASE; dwdata = {24'h0, b}; dwe = 4'b0001;
    step();
    idle_bus();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    daddr = a; dwdata = d; dwe = be;
    step();
    idle_bus();
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    daddr = a; dwe = '0; #1;
    d = drdata;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle_bus();
    step(); step();
    reset = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    pready = 1'b1;
    while (pvalid !== 1'b0 && n < max_cyc) begin step(); n++; end
    checks++;
    if (pvalid !== 1'b0) begin
      failures++; $display("FAIL drain_timeout pvalid=%b required=0", pvalid);
    end
    pready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++; if (pvalid !== 1'b0) begin failures++; $display("FAIL reset_pvalid got=%b exp=0", pvalid); end
    checks++; if (pdata !== 8'h00) begin failures++; $display("FAIL reset_pdata got=%h exp=00", pdata); end
    rd(C_STATUS, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL reset_status got=%h exp=00000001", d); end
    rd(C_COUNT, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=00000000", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    rx.delete(); pready = 1'b1;
    push(8'h41); push(8'h42); push(8'h43);
    drain(20);
    checks++; if (rx.size() !== 3) begin failures++; $display("FAIL basic_rx_count got=%0d exp=3", rx.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rx.size() || rx[i] !== exp_b[i]) begin
        failures++; $display("FAIL basic_rx[%0d] got=%h exp=%h", i, (i < rx.size()) ? rx[i] : 8'hxx, exp_b[i]);
      end
    end
    rd(C_COUNT, d);
    checks++; if (d !== 32'd3) begin failures++; $display("FAIL basic_count got=%h exp=00000003", d); end
    rd(C_STATUS, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL basic_status got=%h exp=00000001", d); end
    rd(C_BASE, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL data_read got=%h exp=00000000", d); end
  endtask

  task automatic test_byte_lane();
    rx.delete(); pready = 1'b0;
    wr(C_BASE, 32'h0000_1234, 4'b0010);
    drain(10);
    checks++;
    if (rx.size() !== 1 || rx[0] !== 8'h00) begin
      failures++; $display("FAIL lane_byte got_n=%0d got=%h exp=00", rx.size(), (rx.size() > 0) ? rx[0] : 8'hxx);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    rx.delete(); pready = 1'b0;
    for (int i = 0; i < 9; i++) push(8'h30 + 8'(i));
    rd(C_STATUS, d);
    checks++; if (d !== 32'h0806) begin failures++; $display("FAIL ovf_status got=%h exp=00000806", d); end
    drain(30);
    checks++; if (rx.size() !== 8) begin failures++; $display("FAIL ovf_rx_count got=%0d exp=8", rx.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= rx.size() || rx[i] !== 8'h30 + 8'(i)) begin
        failures++; $display("FAIL ovf_rx[%0d] got=%h exp=%h", i, (i < rx.size()) ? rx[i] : 8'hxx, 8'h30 + 8'(i));
      end
    end
    rd(C_STATUS, d);
    checks++; if (d !== 32'h5) begin failures++; $display("FAIL ovf_sticky got=%h exp=00000005", d); end
  endtask

  task automatic test_ovf_clear();
    logic [31:0] d, c0;
    wr(C_STATUS, 32'h4, 4'b0010);
    rd(C_STATUS, d);
    checks++; if (d !== 32'h5) begin failures++; $display("FAIL clr_wrong_lane got=%h exp=00000005", d); end
    wr(C_STATUS, 32'h0, 4'b0001);
    rd(C_STATUS, d);
    checks++; if (d !== 32'h5) begin failures++; $display("FAIL clr_bit2_zero got=%h exp=00000005", d); end
    rd(C_COUNT, c0);
    wr(C_COUNT, 32'h0, 4'hF);
    rd(C_COUNT, d);
    checks++; if (d !== 32'd12) begin failures++; $display("FAIL count_write_ignored got=%h exp=0000000c", d); end
    wr(C_STATUS, 32'h4, 4'b0001);
    rd(C_STATUS, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL clr_status got=%h exp=00000001", d); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d;
    rx.delete(); pready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h70 + 8'(i));
    rd(C_STATUS, d);
    checks++; if (d !== 32'h0802) begin failures++; $display("FAIL full_status got=%h exp=00000802", d); end
    // Push into a full FIFO while the head leaves in the same cycle.
    pready = 1'b1; daddr = C_BASE; dwdata = 32'h78; dwe = 4'b0001;
    #1;
    checks++; if (drdata !== 32'h0) begin failures++; $display("FAIL full_data_read got=%h exp=0", drdata); end
    step();
    pready = 1'b0; idle_bus();
    rd(C_STATUS, d);
    checks++; if (d !== 32'h0802) begin failures++; $display("FAIL pushpop_status got=%h exp=00000802", d); end
    drain(30);
    checks++; if (rx.size() !== 9) begin failures++; $display("FAIL pushpop_rx_count got=%0d exp=9", rx.size()); end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= rx.size() || rx[i] !== 8'h70 + 8'(i)) begin
        failures++; $display("FAIL pushpop_rx[%0d] got=%h exp=%h", i, (i < rx.size()) ? rx[i] : 8'hxx, 8'h70 + 8'(i));
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [31:0] d;
    pready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
    pready = 1'b1; step();
    pready = 1'b0; step();
    pready = 1'b1; reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (pvalid !== 1'b0) begin failures++; $display("FAIL mid_reset_pvalid got=%b exp=0", pvalid); end
    rd(C_STATUS, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL mid_reset_status got=%h exp=00000001", d); end
    rd(C_COUNT, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL mid_reset_count got=%h exp=00000000", d); end
    rx.delete();
    push(8'h5A);
    drain(10);
    checks++;
    if (rx.size() !== 1 || rx[0] !== 8'h5A) begin
      failures++; $display("FAIL mid_reset_z got_n=%0d got=%h exp=5a", rx.size(), (rx.size() > 0) ? rx[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int pushed = 0;
    int cyc = 0;
    do_reset();
    rx.delete();
    while (pushed < 136 && cyc < 4000) begin
      pready = 1'($urandom_range(0, 1));
      if (pushed - rx.size() < C_DEPTH) begin
        daddr = C_BASE; dwdata = {24'h0, 8'(pushed * 7 + 3)}; dwe = 4'b0001;
        pushed++;
      end else begin
        idle_bus();
      end
      step();
      cyc++;
    end
    idle_bus();
    checks++; if (pushed !== 136) begin failures++; $display("FAIL burst_timeout pushed=%0d exp=136", pushed); end
    drain(40);
    checks++; if (rx.size() !== 136) begin failures++; $display("FAIL burst_rx_count got=%0d exp=136", rx.size()); end
    for (int i = 0; i < 136; i++) begin
      if (i < rx.size()) begin
        checks++;
        if (rx[i] !== 8'(i * 7 + 3)) begin
          failures++; $display("FAIL burst_rx[%0d] got=%h exp=%h", i, rx[i], 8'(i * 7 + 3));
        end
      end
    end
    rd(C_COUNT, d);
    checks++; if (d !== 32'd136) begin failures++; $display("FAIL burst_count got=%0d exp=136", d); end
    rd(C_STATUS, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL burst_status got=%h exp=00000001", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lane();
    test_overflow();
    test_ovf_clear();
    test_push_pop_full();
    test_reset_mid_drain();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/out_fifo_ctrl.md
OUT_FIFO_CTRL -- requirements
Module: out_fifo_ctrl

Interface
REQ-001 SHALL have parameter: DEPTH, 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter: BASE, 32'h00004000, byte address of the DATA register; STATUS = BASE+4, COUNT = BASE+8.
REQ-003 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: daddr  input  32  CPU data-bus address.
REQ-006 SHALL have port: dwdata  input  32  CPU write data.
REQ-007 SHALL have port: dwe  input  4  CPU byte write enables; any nonzero bit marks a write.
REQ-008 SHALL have port: drdata  output  32  CPU read data, combinational from daddr.
REQ-009 SHALL have port: pdata  output  8  character presented to the output sink.
REQ-010 SHALL have port: pvalid  output  1  pdata holds a valid character.
REQ-011 SHALL have port: pready  input  1  sink accepts pdata this cycle.

Function
REQ-012 SHALL accept a push when daddr == BASE and dwe != 0; pushed byte = dwdata[7:0] if dwe[0], else 8'h00.
REQ-013 SHALL hold pushed bytes in a DEPTH-entry FIFO with wrap-around read/write pointers and a level counter of width clog2(DEPTH)+1.
REQ-014 SHALL drive pvalid = (level != 0) and pdata = head entry, with no combinational path from pready to pvalid/pdata.
REQ-015 SHALL pop the head on any cycle where pvalid && pready; next entry is presented on the following cycle.
REQ-016 SHALL, on simultaneous push and pop, keep level unchanged, including when level == DEPTH (push accepted because pop frees the slot).
REQ-017 SHALL, on a push while level == DEPTH and no pop, drop the byte and set sticky overflow bit; level and pointers unchanged.
REQ-018 SHALL keep a 32-bit sent counter incremented once per pop, wrapping 32'hFFFFFFFF -> 0.
REQ-019 SHALL return on read of STATUS: bit0 empty (level==0), bit1 full (level==DEPTH), bit2 overflow, bits[14:8] level, all other bits 0.
REQ-020 SHALL return sent counter on read of COUNT, and 0 for any other address including DATA.
REQ-021 SHALL clear overflow on a write to STATUS with dwe[0] set and dwdata[2] = 1; other STATUS/COUNT writes ignored; if overflow sets and clears in the same cycle, set wins.
REQ-022 SHALL reflect register state before the clock edge in drdata (read of STATUS in a push cycle shows pre-push level).
REQ-023 SHALL treat daddr comparisons as exact 32-bit matches; X/Z on daddr SHALL not cause a push.

Reset
REQ-024 SHALL, while reset is high at a clock edge, set level, pointers, overflow and sent counter to 0; pushes and pops in that cycle are discarded.
REQ-025 SHALL drive pvalid = 0 and pdata = 8'h00 in the cycle after reset; FIFO storage contents need not be cleared.
REQ-026 SHALL, on reset asserted mid-drain, abandon buffered bytes; sink observes pvalid low from the next cycle.

Verification
REQ-027 Bench SHALL push 'A','B','C' at BASE with pready=1 -> sink receives 41,42,43 in order, one per cycle, COUNT reads 3, STATUS reads 32'h1.
REQ-028 Bench SHALL push 9 bytes 0x30..0x38 with pready=0, DEPTH=8 -> STATUS = 32'h0806 (full, overflow, level 8); release pready -> 0x30..0x37 drained, 0x38 absent.
REQ-029 Bench SHALL push and pop in the same cycle at level 8 -> level stays 8, overflow stays 0, byte accepted and later delivered.
REQ-030 Bench SHALL write 32'h4 with dwe=4'b0001 to STATUS after overflow -> STATUS bit2 reads 0 next cycle; with overflow set same cycle, bit2 reads 1.
REQ-031 Bench SHALL assert reset with 5 bytes queued and pready toggling -> next cycle pvalid=0, STATUS=32'h1, COUNT=0; subsequent push 'Z' delivered as 0x5A.
REQ-032 Bench SHALL write 17 DEPTH-wrapping bursts (136 bytes) with random pready -> sink stream equals push order, COUNT = 136, no overflow.
